// File: rtl/tour_pkg.sv
// Shared constants and state type for the knight's-tour command initiator.
// Command layout: [15:12] opcode, [11:4] heading, [3:0] squares.
package tour_pkg;

   localparam logic [3:0] MOVE    = 4'h2;
   localparam logic [3:0] MOVE_FF = 4'h3;

   localparam logic [7:0] HEAD_N = 8'h00;
   localparam logic [7:0] HEAD_W = 8'h3F;
   localparam logic [7:0] HEAD_S = 8'h7F;
   localparam logic [7:0] HEAD_E = 8'hBF;

   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_POS  = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } state_t;

   function automatic logic [15:0] mk_cmd(
      input logic [3:0] op,
      input logic [7:0] head,
      input logic [1:0] sq
   );
      return {op, head, 2'b00, sq};
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into its vertical and horizontal legs.
// The lowest set bit wins; an empty move decodes to heading N, 0 squares.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] vhead,
   output logic [1:0] vsq,
   output logic [7:0] hhead,
   output logic [1:0] hsq
);

   always_comb begin
      vhead = HEAD_N;
      vsq   = 2'd0;
      hhead = HEAD_N;
      hsq   = 2'd0;
      priority case (1'b1)
         move[0]: begin
            vhead = HEAD_N; vsq = 2'd2;
            hhead = HEAD_W; hsq = 2'd1;
         end
         move[1]: begin
            vhead = HEAD_N; vsq = 2'd2;
            hhead = HEAD_E; hsq = 2'd1;
         end
         move[2]: begin
            vhead = HEAD_N; vsq = 2'd1;
            hhead = HEAD_W; hsq = 2'd2;
         end
         move[3]: begin
            vhead = HEAD_S; vsq = 2'd1;
            hhead = HEAD_W; hsq = 2'd2;
         end
         move[4]: begin
            vhead = HEAD_S; vsq = 2'd2;
            hhead = HEAD_W; hsq = 2'd1;
         end
         move[5]: begin
            vhead = HEAD_S; vsq = 2'd2;
            hhead = HEAD_E; hsq = 2'd1;
         end
         move[6]: begin
            vhead = HEAD_S; vsq = 2'd1;
            hhead = HEAD_E; hsq = 2'd2;
         end
         move[7]: begin
            vhead = HEAD_N; vsq = 2'd1;
            hhead = HEAD_E; hsq = 2'd2;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tour_cmd.sv
// Tour command initiator: issues vertical then horizontal commands per move,
// and passes UART commands straight through when no tour is running.
module tour_cmd
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tour_go,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  idx_nxt;
   logic [7:0]  vhead;
   logic [1:0]  vsq;
   logic [7:0]  hhead;
   logic [1:0]  hsq;
   logic [15:0] vcmd;
   logic [15:0] hcmd;
   logic        last;

   tour_move_decode u_dec (
      .move  (move),
      .vhead (vhead),
      .vsq   (vsq),
      .hhead (hhead),
      .hsq   (hsq)
   );

   assign vcmd = mk_cmd(MOVE, vhead, vsq);
   assign hcmd = mk_cmd(MOVE_FF, hhead, hsq);
   assign last = (mv_indx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= 5'd0;
      end else begin
         state   <= state_nxt;
         mv_indx <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      idx_nxt          = mv_indx;
      cmd              = vcmd;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_POS;
      unique case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
            if (tour_go) begin
               idx_nxt   = 5'd0;
               state_nxt = VERT;
            end
         end
         VERT: begin
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy) state_nxt = WAIT_V;
         end
         WAIT_V: begin
            if (send_resp) state_nxt = HORZ;
         end
         HORZ: begin
            cmd     = hcmd;
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy) state_nxt = WAIT_H;
         end
         WAIT_H: begin
            cmd = hcmd;
            // Final response of the tour reads as done
            if (last) resp = RESP_DONE;
            if (send_resp) begin
               if (last) begin
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = mv_indx + 5'd1;
                  state_nxt = VERT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tour_cmd.sv
// Bench for tour_cmd: move-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_tour_cmd;
   import tour_pkg::*;

   localparam int N = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tour_go = 1'b0;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART = 16'h0;
   logic        cmd_rdy_UART = 1'b0;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        send_resp = 1'b0;
   logic [7:0]  resp;

   logic [7:0]  mem [32];
   logic [15:0] acc_q [$];

   int tests = 0;
   int fails = 0;

   bit m_in;
   bit m_acc;
   int m_k;
   int m_idx;

   always #5 clk = ~clk;

   assign move = mem[mv_indx];

   tour_cmd #(.NUM_MOVES(N)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .tour_go          (tour_go),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp)
   );

   // Command for leg `horz` of a move, from the knight-move table
   function automatic logic [15:0] exp_cmd(logic [7:0] mv, bit horz);
      int vh [8] = '{'h00, 'h00, 'h00, 'h7F, 'h7F, 'h7F, 'h7F, 'h00};
      int vs [8] = '{2, 2, 1, 1, 2, 2, 1, 1};
      int hh [8] = '{'h3F, 'hBF, 'h3F, 'h3F, 'h3F, 'hBF, 'hBF, 'hBF};
      int hs [8] = '{1, 1, 2, 2, 1, 1, 2, 2};
      int b = -1;
      for (int i = 7; i >= 0; i--)
         if (mv[i]) b = i;
      if (b < 0) return horz ? 16'h3000 : 16'h2000;
      if (!horz) return 16'((2 << 12) | (vh[b] << 4) | vs[b]);
      return 16'((3 << 12) | (hh[b] << 4) | hs[b]);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!cmd_rdy && n < 60) begin
         tick();
         n++;
      end
      if (!cmd_rdy) chk("rdy_timeout", 32'(cmd_rdy), 32'd1);
   endtask

   task automatic ack(int d1, int d2);
      wait_rdy();
      repeat (d1) tick();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      repeat (d2) tick();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
   endtask

   // Reference model: tour progress as a command count k and an accepted flag
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_in = 0; m_acc = 0; m_k = 0; m_idx = 0;
         end
         if (m_in) begin
            chk("m_cmd", 32'(cmd), 32'(exp_cmd(mem[m_k / 2], bit'(m_k % 2))));
            chk("m_rdy", 32'(cmd_rdy), 32'(!m_acc));
            chk("m_clru", 32'(clr_cmd_rdy_UART), 32'd0);
            chk("m_resp", 32'(resp),
                (m_k == 2 * N - 1 && m_acc) ? 32'hA5 : 32'h5A);
            chk("m_idx", 32'(mv_indx), 32'(m_k / 2));
         end else begin
            chk("m_cmd", 32'(cmd), 32'(cmd_UART));
            chk("m_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
            chk("m_clru", 32'(clr_cmd_rdy_UART), 32'(clr_cmd_rdy));
            chk("m_resp", 32'(resp), 32'hA5);
            chk("m_idx", 32'(mv_indx), 32'(m_idx));
         end
         if (rst_n) begin
            if (!m_in) begin
               if (tour_go) begin
                  m_in = 1; m_k = 0; m_acc = 0;
               end
            end else if (!m_acc) begin
               if (clr_cmd_rdy) begin
                  acc_q.push_back(cmd);
                  m_acc = 1;
               end
            end else if (send_resp) begin
               if (m_k == 2 * N - 1) begin
                  m_in = 0;
                  m_idx = N - 1;
               end else begin
                  m_k++;
                  m_acc = 0;
               end
            end
            if (m_in) m_idx = m_k / 2;
         end
      end
   end

   initial begin
      int d1;
      int d2;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;

      chk("pin_01v", 32'(exp_cmd(8'h01, 0)), 32'h2002);
      chk("pin_01h", 32'(exp_cmd(8'h01, 1)), 32'h33F1);
      chk("pin_40v", 32'(exp_cmd(8'h40, 0)), 32'h27F1);
      chk("pin_06h", 32'(exp_cmd(8'h06, 1)), 32'h3BF1);

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_idx", 32'(mv_indx), 32'd0);
      chk("rst_resp", 32'(resp), 32'hA5);

      cmd_UART = 16'h2F52;
      cmd_rdy_UART = 1'b1;
      #1;
      chk("pt_cmd", 32'(cmd), 32'h2F52);
      chk("pt_rdy", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1;
      #1;
      chk("pt_clru", 32'(clr_cmd_rdy_UART), 32'd1);
      tick();
      clr_cmd_rdy = 1'b0;
      cmd_rdy_UART = 1'b0;

      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
      mem[4] = 8'h10; mem[5] = 8'h40; mem[6] = 8'h06; mem[7] = 8'h00;
      mem[8] = 8'h80;
      tour_go = 1'b1;
      tick();
      tour_go = 1'b0;
      chk("v0_cmd", 32'(cmd), 32'h2002);
      chk("v0_rdy", 32'(cmd_rdy), 32'd1);
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("v0_hold", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      chk("wv_rdy", 32'(cmd_rdy), 32'd0);
      chk("wv_cmd", 32'(cmd), 32'h2002);

      cmd_rdy_UART = 1'b1;
      clr_cmd_rdy = 1'b1;
      tour_go = 1'b1;
      #1;
      chk("mid_clru", 32'(clr_cmd_rdy_UART), 32'd0);
      tick();
      clr_cmd_rdy = 1'b0;
      tour_go = 1'b0;
      chk("mid_idx", 32'(mv_indx), 32'd0);
      chk("mid_rdy", 32'(cmd_rdy), 32'd0);

      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("h0_cmd", 32'(cmd), 32'h33F1);
      chk("h0_rdy", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1;
      send_resp = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      send_resp = 1'b0;
      chk("wh_rdy", 32'(cmd_rdy), 32'd0);
      chk("wh_idx", 32'(mv_indx), 32'd0);
      chk("wh_resp", 32'(resp), 32'h5A);
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("v1_idx", 32'(mv_indx), 32'd1);

      repeat (8) ack(0, 1);
      chk("v5_idx", 32'(mv_indx), 32'd5);
      chk("v5_cmd", 32'(cmd), 32'h27F1);
      ack(1, 3);
      wait_rdy();
      chk("h5_cmd", 32'(cmd), 32'h3BF2);
      ack(0, 2);
      chk("v6_idx", 32'(mv_indx), 32'd6);
      chk("v6_resp", 32'(resp), 32'h5A);
      chk("v6_cmd", 32'(cmd), 32'h2002);
      ack(0, 1);
      wait_rdy();
      chk("h6_cmd", 32'(cmd), 32'h3BF1);
      ack(0, 1);
      chk("v7_cmd", 32'(cmd), 32'h2000);
      ack(0, 1);
      wait_rdy();
      chk("h7_cmd", 32'(cmd), 32'h3000);
      ack(0, 1);
      ack(0, 1);
      wait_rdy();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      chk("wh8_idx", 32'(mv_indx), 32'd8);
      cmd_UART = 16'h1234;
      rst_n = 1'b0;
      #1;
      chk("rr_idx", 32'(mv_indx), 32'd0);
      chk("rr_resp", 32'(resp), 32'hA5);
      chk("rr_cmd", 32'(cmd), 32'h1234);
      tick();
      rst_n = 1'b1;
      cmd_rdy_UART = 1'b0;
      tick();

      for (int i = 0; i < N; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
      acc_q.delete();
      tour_go = 1'b1;
      tick();
      tour_go = 1'b0;
      for (int j = 0; j < 2 * N; j++) begin
         wait_rdy();
         d1 = $urandom_range(0, 2);
         d2 = $urandom_range(2, 19);
         repeat (d1) tick();
         clr_cmd_rdy = 1'b1;
         tick();
         clr_cmd_rdy = 1'b0;
         repeat (d2) tick();
         send_resp = 1'b1;
         #1;
         if (j == 2 * N - 1) chk("fin_resp", 32'(resp), 32'hA5);
         tick();
         send_resp = 1'b0;
      end
      tick();
      chk("run_count", 32'(acc_q.size()), 32'(2 * N));
      for (int j = 0; j < acc_q.size() && j < 2 * N; j++)
         chk("run_order", 32'(acc_q[j]), 32'(exp_cmd(mem[j / 2], bit'(j % 2))));
      chk("end_idx", 32'(mv_indx), 32'd23);
      chk("end_resp", 32'(resp), 32'hA5);
      cmd_UART = 16'h2F52;
      cmd_rdy_UART = 1'b1;
      #1;
      chk("end_pt_cmd", 32'(cmd), 32'h2F52);
      chk("end_pt_rdy", 32'(cmd_rdy), 32'd1);
      tick();
      cmd_rdy_UART = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
tour_cmd is the initiator that feeds the command processor's cmd/cmd_rdy/clr_cmd_rdy/send_resp interface. When a tour is requested, it walks the solved move list and splits each knight L-move into two commands: a vertical move, then a horizontal move with fanfare. Each command waits for the processor's completion response before the next is issued. Outside a tour it passes UART commands straight through, so the command processor sees a single command source.

Parameters:
NUM_MOVES, 24, number of moves in a full tour (5x5 board); mv_indx runs 0..NUM_MOVES-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tour_go  in  1  one-cycle pulse from the command processor; starts a tour
move  in  8  one-hot move read from move memory at mv_indx
mv_indx  out  5  index of the move being executed
cmd_UART  in  16  command from the UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  clear back to the UART wrapper (pass-through only)
cmd  out  16  command to the command processor
cmd_rdy  out  1  command valid to the command processor
clr_cmd_rdy  in  1  command processor has accepted cmd
send_resp  in  1  command processor finished the command
resp  out  8  response byte sent to the host

Behaviour:
- Command format: [15:12] opcode (MOVE=4'h2, MOVE_FF=4'h3), [11:4] heading, [3:0] squares.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode uses the lowest set bit of move. Listed as bit: vertical part; horizontal part.
  - bit 0: N2; W1
  - bit 1: N2; E1
  - bit 2: N1; W2
  - bit 3: S1; W2
  - bit 4: S2; W1
  - bit 5: S2; E1
  - bit 6: S1; E2
  - bit 7: N1; E2
- move==0: both commands are still issued, heading N, 0 squares.
- Vertical command = {MOVE, vhead, 2'b00, vsq}. Horizontal command = {MOVE_FF, hhead, 2'b00, hsq}.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- IDLE (pass-through):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
  - tour_go: mv_indx<=0, go to VERT next cycle.
- VERT: cmd=vertical command, cmd_rdy=1 held until clr_cmd_rdy, then go to WAIT_V.
- WAIT_V: cmd held, cmd_rdy=0. On send_resp go to HORZ.
- HORZ: cmd=horizontal command, cmd_rdy=1 until clr_cmd_rdy, then go to WAIT_H.
- WAIT_H, on send_resp:
  - if mv_indx==NUM_MOVES-1: go to IDLE, mv_indx unchanged.
  - else: mv_indx<=mv_indx+1, go to VERT.
- In every non-IDLE state:
  - clr_cmd_rdy_UART=0; cmd_rdy_UART is ignored and stays pending in the wrapper.
  - resp=8'h5A, except resp=8'hA5 in WAIT_H when mv_indx==NUM_MOVES-1, so the final response reads A5.
- Registered: state, mv_indx. Combinational: cmd, cmd_rdy, resp, clr_cmd_rdy_UART, decoded from state, move and inputs.
- move is sampled combinationally. Move memory must present move[mv_indx] by the cycle after mv_indx changes; VERT holds cmd_rdy until accepted, so one cycle of skew is tolerated.
- Boundary conditions:
  - tour_go outside IDLE is ignored.
  - send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
  - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: treat as clr only; the next send_resp completes.
  - Reset mid-tour: state=IDLE, mv_indx=0, the tour is abandoned, pass-through resumes.
- Reset values: state=IDLE, mv_indx=0. Outputs therefore equal pass-through of the UART inputs, resp=8'hA5.

Decomposition:
- Package tour_pkg holds:
  - opcode constants MOVE, MOVE_FF;
  - heading constants HEAD_N/W/S/E;
  - RESP_DONE=8'hA5, RESP_POS=8'h5A;
  - the state enum typedef.
- One combinational sub-module, tour_move_decode: move[7:0] in; vhead, vsq, hhead, hsq out. This keeps the decode table unit-testable.

Test Plan:
- Reset, then cmd_UART=16'h2F52 with cmd_rdy_UART=1 → cmd=16'h2F52, cmd_rdy=1; clr_cmd_rdy pulse → clr_cmd_rdy_UART=1 the same cycle; resp=8'hA5.
- tour_go with move=8'h01 → VERT: cmd=16'h2002, cmd_rdy=1 until clr_cmd_rdy. send_resp → HORZ: cmd=16'h33F1.
- move=8'h40 at mv_indx=5 → cmd 16'h27F1 then 16'h3BF2. After second send_resp: mv_indx=6, resp=8'h5A.
- Full run, NUM_MOVES=24, random one-hot moves, responder model acks after 3–20 cycles:
  - exactly 48 commands issued, in decode-table order;
  - resp=8'hA5 on the 48th send_resp; state returns to IDLE, mv_indx=23.
- Mid-tour:
  - cmd_rdy_UART=1 and a second tour_go → clr_cmd_rdy_UART stays 0, mv_indx unaffected.
  - Assert rst_n low in WAIT_H → IDLE, mv_indx=0.
- move=8'h06 (two bits set) → bit 1 decode used: 16'h2002 then 16'h3BF1. move=8'h00 → 16'h2000 then 16'h3000.
